mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory stage executor downstream of the load/store decode. Takes the decoded
//  op (1=read, 0=write), access_size and read_unsigned plus the effective address
//  and store data, and runs one req/ack transaction on the word-wide data bus.
//  It aligns byte lanes, sign/zero-extends load data, and flags misaligned,
//  bus-error and timeout faults to the writeback/trap logic.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles bus_req may wait for bus_ack/bus_err before timeout fault (1..255)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  reset            in   1   synchronous, active-high
//  start            in   1   one-cycle request; sampled only in IDLE
//  mem_op           in   1   1=read(load), 0=write(store)
//  access_size      in   2   00=byte 01=half 10=word 11=illegal
//  read_unsigned    in   1   1=zero-extend load, 0=sign-extend
//  addr             in   32  byte address
//  store_data       in   32  store value, right-justified
//  busy             out  1   high from cycle after accepted start until done
//  done             out  1   one-cycle completion pulse
//  load_data        out  32  extended load result, valid with done; held until next done
//  fault            out  1   valid with done; 1 = access failed
//  fault_cause      out  2   01=misaligned/illegal size 10=bus_err 11=timeout 00=none
//  bus_req          out  1   transaction request, held until bus_ack or bus_err
//  bus_we           out  1   1=write
//  bus_addr         out  32  {addr[31:2],2'b00}
//  bus_be           out  4   byte enables
//  bus_wdata        out  32  lane-replicated store data
//  bus_ack          in   1   transaction complete (rdata valid for reads)
//  bus_err          in   1   transaction error; wins over bus_ack if both high
//  bus_rdata        in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, fault, bus_req, bus_we = 0; load_data,
//   fault_cause, bus_addr, bus_be, bus_wdata = 0; timeout counter = 0.
//  FSM: IDLE -> (start & aligned) REQ; IDLE -> (start & misaligned) FAULT;
//   REQ -> (bus_err) FAULT; REQ -> (bus_ack) DONE; REQ -> (counter==TIMEOUT_CYCLES) FAULT;
//   DONE -> IDLE; FAULT -> IDLE.
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=0; size 11 always
//   faults with cause 01. Misaligned never asserts bus_req.
//  On accepted start, all inputs are registered; later input changes are ignored.
//  start while busy or in DONE/FAULT is ignored (not queued).
//  bus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//  bus_wdata: byte {4{sd[7:0]}}; half {2{sd[15:0]}}; word sd.
//  bus_req/bus_we/bus_addr/bus_be/bus_wdata valid in every REQ cycle; bus_req
//   drops the cycle after ack/err is seen.
//  Load extraction: select the lane given by addr[1:0]; extend per read_unsigned
//   to 32 bits. Stores complete with load_data unchanged.
//  Timeout counter: cleared on entering REQ, +1 each REQ cycle without ack/err;
//   saturates (no wrap).
//  done pulses in the DONE or FAULT state cycle; fault=1 only in FAULT.
//  Latency: start at cycle T, ack at T+k (k>=1) -> done at T+k+1. Misaligned:
//   done+fault at T+1.
//  Reset mid-transaction: bus_req drops next cycle, no done pulse, any late
//   ack is ignored in IDLE.
// TESTING
//  Byte load addr=0x1003, rdata=0x80xx_xxxx, unsigned=0 -> be=1000, load_data=0xFFFFFF80.
//  Half store addr=0x2002 sd=0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, done 1 cycle after ack.
//  Word load addr=0x3001 -> no bus_req, done+fault next cycle, cause=01.
//  Read with bus_err and bus_ack both high -> fault=1, cause=10, load_data unchanged.
//  No ack for TIMEOUT_CYCLES=4 -> bus_req drops, done+fault, cause=11.
//  reset asserted during REQ -> bus_req=0, busy=0 next cycle, no done.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage executor: runs one req/ack bus transaction per accepted start,
// aligning byte lanes, extending load data and reporting misaligned/bus/timeout faults.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mem_op,
   input  logic [1:0]  access_size,
   input  logic        read_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DONE  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
   localparam logic [1:0] CAUSE_BUS     = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      state;
   state_t      state_next;
   logic        read_r;
   logic        write_r;
   logic [1:0]  size_r;
   logic        unsigned_r;
   logic [1:0]  lane_r;
   logic [7:0]  wait_cnt;

   logic        aligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // Size 11 is never aligned, so it takes the same fault path as misalignment.
   always_comb begin
      aligned   = 1'b0;
      be_new    = 4'b0000;
      wdata_new = 32'd0;
      case (access_size)
         2'b00: begin
            aligned   = 1'b1;
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{store_data[7:0]}};
         end
         2'b01: begin
            aligned   = (addr[0] == 1'b0);
            be_new    = 4'b0011 << addr[1:0];
            wdata_new = {2{store_data[15:0]}};
         end
         2'b10: begin
            aligned   = (addr[1:0] == 2'b00);
            be_new    = 4'b1111;
            wdata_new = store_data;
         end
         default: begin
            aligned   = 1'b0;
            be_new    = 4'b0000;
            wdata_new = 32'd0;
         end
      endcase
   end

   always_comb begin
      byte_sel = 8'd0;
      half_sel = lane_r[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (lane_r)
         2'd0:    byte_sel = bus_rdata[7:0];
         2'd1:    byte_sel = bus_rdata[15:8];
         2'd2:    byte_sel = bus_rdata[23:16];
         default: byte_sel = bus_rdata[31:24];
      endcase
      case (size_r)
         2'b00:   load_ext = {{24{~unsigned_r & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~unsigned_r & half_sel[15]}}, half_sel};
         default: load_ext = bus_rdata;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) state_next = aligned ? S_REQ : S_FAULT;
         end
         S_REQ: begin
            if (bus_err)                        state_next = S_FAULT;
            else if (bus_ack)                   state_next = S_DONE;
            else if (wait_cnt == TIMEOUT_LIMIT) state_next = S_FAULT;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         read_r      <= 1'b0;
         write_r     <= 1'b0;
         size_r      <= 2'b00;
         unsigned_r  <= 1'b0;
         lane_r      <= 2'b00;
         wait_cnt    <= 8'd0;
         load_data   <= 32'd0;
         fault_cause <= CAUSE_NONE;
         bus_addr    <= 32'd0;
         bus_be      <= 4'b0000;
         bus_wdata   <= 32'd0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (start) begin
                  read_r     <= mem_op;
                  write_r    <= ~mem_op;
                  size_r     <= access_size;
                  unsigned_r <= read_unsigned;
                  lane_r     <= addr[1:0];
                  wait_cnt   <= 8'd0;
                  if (aligned) begin
                     bus_addr    <= {addr[31:2], 2'b00};
                     bus_be      <= be_new;
                     bus_wdata   <= wdata_new;
                     fault_cause <= CAUSE_NONE;
                  end else begin
                     fault_cause <= CAUSE_ALIGN;
                  end
               end
            end
            S_REQ: begin
               if (bus_err) begin
                  fault_cause <= CAUSE_BUS;
               end else if (bus_ack) begin
                  fault_cause <= CAUSE_NONE;
                  if (read_r) load_data <= load_ext;
               end else if (wait_cnt == TIMEOUT_LIMIT) begin
                  fault_cause <= CAUSE_TIMEOUT;
               end else if (wait_cnt != 8'hFF) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state == S_REQ);
   assign bus_req = (state == S_REQ);
   assign bus_we  = (state == S_REQ) && write_r;
   assign done    = (state == S_DONE) || (state == S_FAULT);
   assign fault   = (state == S_FAULT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single transactions plus
// hand-written timeout, reset-abort and ignored-start sequences.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mem_op;
   logic [1:0]  access_size;
   logic        read_unsigned;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .mem_op(mem_op),
      .access_size(access_size), .read_unsigned(read_unsigned), .addr(addr),
      .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
      .fault(fault), .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdata;
      int          delay;
      logic        ack;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        flt;
      logic [1:0]  cause;
      logic        ld_upd;
      logic [31:0] ld;
   } vec_t;

   vec_t        vecs[13];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] ld_hold = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_start(input logic op, input logic [1:0] size, input logic uns,
                              input logic [31:0] a, input logic [31:0] sd);
      @(negedge clk);
      mem_op = op; access_size = size; read_unsigned = uns; addr = a; store_data = sd;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Scramble inputs so any late sampling by the DUT shows up.
      mem_op = ~op; access_size = ~size; read_unsigned = ~uns;
      addr = ~a; store_data = ~sd;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      drive_start(v.op, v.size, v.uns, v.addr, v.sd);
      if (v.cause == 2'b01) begin
         check({tag, "_req"},   {31'd0, bus_req}, 32'd0);
         check({tag, "_done"},  {31'd0, done}, 32'd1);
         check({tag, "_fault"}, {31'd0, fault}, 32'd1);
         check({tag, "_cause"}, {30'd0, fault_cause}, 32'd1);
         check({tag, "_ld"},    load_data, ld_hold);
      end else begin
         check({tag, "_req"},  {31'd0, bus_req}, 32'd1);
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_addr"}, bus_addr, {v.addr[31:2], 2'b00});
         check({tag, "_be"},   {28'd0, bus_be}, {28'd0, v.be});
         check({tag, "_we"},   {31'd0, bus_we}, {31'd0, ~v.op});
         if (!v.op) check({tag, "_wdata"}, bus_wdata, v.wdata);
         for (int i = 1; i < v.delay; i++) begin
            @(negedge clk);
            check({tag, "_wait_done"}, {31'd0, done}, 32'd0);
         end
         bus_ack = v.ack; bus_err = v.err; bus_rdata = v.rdata;
         @(negedge clk);
         bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'hDEAD_0000;
         check({tag, "_done"},  {31'd0, done}, 32'd1);
         check({tag, "_fault"}, {31'd0, fault}, {31'd0, v.flt});
         check({tag, "_cause"}, {30'd0, fault_cause}, {30'd0, v.cause});
         check({tag, "_reqoff"}, {31'd0, bus_req}, 32'd0);
         if (v.ld_upd) ld_hold = v.ld;
         check({tag, "_ld"}, load_data, ld_hold);
      end
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int req_cycles;
      logic seen_done;

      //          op    sz     uns   addr          sd            rdata         dly ack   err   be       wdata         flt   cause  upd   ld
      vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0,       32'h8012_3456, 1, 1'b1, 1'b0, 4'b1000, 32'h0,        1'b0, 2'b00, 1'b1, 32'hFFFF_FF80};
      vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0,       2, 1'b1, 1'b0, 4'b1100, 32'hABCD_ABCD, 1'b0, 2'b00, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h0,       32'h0,         1, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h0,       32'h5555_5555, 1, 1'b1, 1'b1, 4'b1111, 32'h0,        1'b1, 2'b10, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 2'b00, 1'b1, 32'h0000_5001, 32'h0,       32'h1122_F344, 3, 1'b1, 1'b0, 4'b0010, 32'h0,        1'b0, 2'b00, 1'b1, 32'h0000_00F3};
      vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_6000, 32'h0,       32'h0000_8001, 1, 1'b1, 1'b0, 4'b0011, 32'h0,        1'b0, 2'b00, 1'b1, 32'hFFFF_8001};
      vecs[6]  = '{1'b1, 2'b01, 1'b1, 32'h0000_6002, 32'h0,       32'hBEEF_0000, 2, 1'b1, 1'b0, 4'b1100, 32'h0,        1'b0, 2'b00, 1'b1, 32'h0000_BEEF};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,       1, 1'b1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h0000_8002, 32'h0000_00A5, 32'h0,       1, 1'b1, 1'b0, 4'b0100, 32'hA5A5_A5A5, 1'b0, 2'b00, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 2'b11, 1'b0, 32'h0000_9000, 32'h0,       32'h0,         1, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0};
      vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_A001, 32'h0,       32'h0,         1, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_B004, 32'h0,       32'h7F00_FF01, 1, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b0, 2'b00, 1'b1, 32'h7F00_FF01};
      vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_C000, 32'h0000_0011, 32'h0,       2, 1'b0, 1'b1, 4'b0001, 32'h1111_1111, 1'b1, 2'b10, 1'b0, 32'h0};

      reset = 1'b1; start = 1'b0; mem_op = 1'b0; access_size = 2'b00; read_unsigned = 1'b0;
      addr = 32'd0; store_data = 32'd0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_req",   {31'd0, bus_req}, 32'd0);
      check("rst_we",    {31'd0, bus_we}, 32'd0);
      check("rst_ld",    load_data, 32'd0);
      check("rst_cause", {30'd0, fault_cause}, 32'd0);
      check("rst_addr",  bus_addr, 32'd0);
      check("rst_be",    {28'd0, bus_be}, 32'd0);
      check("rst_wdata", bus_wdata, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // No response: bus_req is held for TIMEOUT_CYCLES+1 cycles, then a timeout fault.
      drive_start(1'b1, 2'b10, 1'b0, 32'h0000_D000, 32'h0);
      req_cycles = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 20 && !seen_done; i++) begin
         if (done) seen_done = 1'b1;
         else begin
            if (bus_req) req_cycles++;
            @(negedge clk);
         end
      end
      check("to_seen",   {31'd0, seen_done}, 32'd1);
      check("to_cycles", req_cycles, 32'd5);
      check("to_fault",  {31'd0, fault}, 32'd1);
      check("to_cause",  {30'd0, fault_cause}, 32'd3);
      check("to_req",    {31'd0, bus_req}, 32'd0);
      check("to_ld",     load_data, ld_hold);

      // Reset during REQ: bus side drops next cycle, a late ack is ignored.
      drive_start(1'b1, 2'b00, 1'b0, 32'h0000_E000, 32'h0);
      check("rr_req", {31'd0, bus_req}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rr_req_off",  {31'd0, bus_req}, 32'd0);
      check("rr_busy_off", {31'd0, busy}, 32'd0);
      check("rr_done",     {31'd0, done}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h0000_00FF;
      @(negedge clk);
      bus_ack = 1'b0;
      check("rr_late_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("rr_late_done2", {31'd0, done}, 32'd0);
      check("rr_ld", load_data, 32'd0);
      ld_hold = 32'd0;

      // start pulsed during REQ and during DONE is dropped, not queued.
      drive_start(1'b1, 2'b10, 1'b0, 32'h0000_F000, 32'h0);
      start = 1'b1; addr = 32'h0000_1234; mem_op = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("ig_addr", bus_addr, 32'h0000_F000);
      check("ig_we",   {31'd0, bus_we}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      bus_ack = 1'b0;
      start = 1'b1;
      check("ig_done", {31'd0, done}, 32'd1);
      check("ig_ld",   load_data, 32'h0BAD_F00D);
      @(negedge clk);
      start = 1'b0;
      check("ig_req_after", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      check("ig_req_after2", {31'd0, bus_req}, 32'd0);
      check("ig_done_after", {31'd0, done}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
